// File: rtl/aes_pkg.sv
// Shared AES constants and byte/word/state helpers for the encrypt and decrypt cores.
package aes_pkg;

  localparam int unsigned BlockW     = 128;
  localparam int unsigned KeyW       = 128;
  localparam int unsigned RoundKeysW = 1408;

  localparam logic [0:255][7:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] InvSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f939c9cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [0:9][7:0] Rcon = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return Sbox[b];
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
    return InvSbox[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {Sbox[w[31:24]], Sbox[w[23:16]], Sbox[w[15:8]], Sbox[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // State byte i lives at bits [127-8i -: 8]; row = i % 4, column = i / 4.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = Sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Combinational AES-128 key schedule; round key r sits at bits [1407-128r -: 128].
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned N  = 128,
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4
) (
  input  logic [N-1:0]          key_i,
  output logic [128*(Nr+1)-1:0] round_keys_o
);

  localparam int unsigned NumWords = 4 * (Nr + 1);
  localparam int unsigned BusW     = 128 * (Nr + 1);

  for (genvar i = 0; i < NumWords; i++) begin : g_w
    logic [31:0] word;
    if (i < Nk) begin : g_key
      assign word = key_i[N-1-32*i -: 32];
    end else if (i % Nk == 0) begin : g_rcon
      assign word = g_w[i-Nk].word ^ sub_word(rot_word(g_w[i-1].word))
                  ^ {Rcon[i/Nk-1], 24'h000000};
    end else begin : g_plain
      assign word = g_w[i-Nk].word ^ g_w[i-1].word;
    end
    assign round_keys_o[BusW-1-32*i -: 32] = word;
  end

endmodule

// File: rtl/encrypt.sv
// AES-128 encryption: fully unrolled combinational cipher with one output register.
module encrypt
  import aes_pkg::*;
#(
  parameter int unsigned N  = 128,
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      key_in,
  input  logic [BlockW-1:0] in_1,
  output logic [BlockW-1:0] out
);

  localparam int unsigned BusW = 128 * (Nr + 1);

  logic [BusW-1:0]   round_keys;
  logic [BlockW-1:0] out_q;

  aes_key_expand #(
    .N  (N),
    .Nr (Nr),
    .Nk (Nk)
  ) u_key_expand (
    .key_i        (key_in),
    .round_keys_o (round_keys)
  );

  for (genvar r = 0; r <= Nr; r++) begin : g_rnd
    logic [BlockW-1:0] state;
    if (r == 0) begin : g_init
      assign state = in_1 ^ round_keys[BusW-1 -: 128];
    end else if (r < Nr) begin : g_mid
      assign state = mix_columns(shift_rows(sub_bytes(g_rnd[r-1].state)))
                   ^ round_keys[BusW-1-128*r -: 128];
    end else begin : g_last
      assign state = shift_rows(sub_bytes(g_rnd[r-1].state))
                   ^ round_keys[BusW-1-128*r -: 128];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= g_rnd[Nr].state;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_encrypt.sv
// Directed known-answer bench for the encrypt core, including back-to-back and mid-stream reset.
module tb_encrypt;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic [127:0] in_1;
  logic [127:0] out;

  int unsigned num_checks;
  int unsigned num_errors;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CtZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] PtEcb = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CtEcb = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  encrypt #(
    .N  (128),
    .Nr (10),
    .Nk (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .in_1   (in_1),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [127:0] k, input logic [127:0] p);
    key_in = k;
    in_1   = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    rst = 1'b0;
    apply(KeyC1, PtC1);
    #2;
    check_value("reset_out", out, 128'h0);
    tick();
    check_value("reset_held_edge", out, 128'h0);

    @(negedge clk);
    rst = 1'b1;
    tick();
    check_value("fips_c1", out, CtC1);

    apply(KeyB, PtB);
    tick();
    check_value("fips_b", out, CtB);

    apply(128'h0, 128'h0);
    tick();
    check_value("all_zero", out, CtZ);

    apply(KeyB, PtEcb);
    tick();
    check_value("sp800_ecb", out, CtEcb);

    // Consecutive edges, one vector per clock.
    apply(KeyC1, PtC1);
    tick();
    check_value("b2b_0", out, CtC1);
    apply(KeyB, PtB);
    tick();
    check_value("b2b_1", out, CtB);
    apply(128'h0, 128'h0);
    tick();
    check_value("b2b_2", out, CtZ);
    tick();
    check_value("hold_const", out, CtZ);

    apply(KeyB, PtB);
    tick();
    check_value("pre_reset", out, CtB);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("async_reset", out, 128'h0);
    tick();
    check_value("reset_edge_1", out, 128'h0);
    tick();
    check_value("reset_edge_2", out, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_value("release_no_edge", out, 128'h0);
    tick();
    check_value("post_release", out, CtB);

    apply(KeyC1, PtC1);
    tick();
    check_value("key_and_data_change", out, CtC1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
